nf10_axis_memcached_bufctrl: RTL and testbench

Sequencer for the memcached client's 64-bit x WC_MAX stream buffer. It accepts a packet as a stream of 32-bit words and writes them through the buffer's 32-bit write port. It then drains the packet as a 64-bit AXI-Stream master through the buffer's 64-bit read port. A single buffer is used, alternating between FILL and DRAIN; the block sits between the request builder and the TX AXIS output.

---
 rtl/nf10_axis_memcached_bufctrl.sv | 113 +++++++++++
 tb/tb_nf10_axis_memcached_bufctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nf10_axis_memcached_bufctrl.sv
// rtl/nf10_axis_memcached_bufctrl.sv - fill/drain sequencer for the memcached client stream buffer
module nf10_axis_memcached_bufctrl #(
    parameter int WC_MAX   = 190,
    parameter int WC_WIDTH = 8
) (
    input  logic                ACLK,
    input  logic                RESET,
    input  logic [31:0]         fill_data,
    input  logic                fill_valid,
    input  logic                fill_last,
    output logic                fill_ready,
    output logic [WC_WIDTH:0]   buf_wr32_addr,
    output logic [31:0]         buf_wr32_data,
    output logic                buf_wr32_en,
    output logic [WC_WIDTH-1:0] buf_rd64_addr,
    input  logic [63:0]         buf_rd64_data,
    output logic [63:0]         M_AXIS_TDATA,
    output logic [7:0]          M_AXIS_TKEEP,
    output logic                M_AXIS_TVALID,
    input  logic                M_AXIS_TREADY,
    output logic                M_AXIS_TLAST,
    output logic                err_overflow
);

    localparam logic [WC_WIDTH:0] WORDS_MAX = (WC_WIDTH + 1)'(2 * WC_MAX);
    localparam logic [WC_WIDTH:0] ONE       = (WC_WIDTH + 1)'(1);

    typedef enum logic [1:0] {S_FILL, S_PRIME, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [WC_WIDTH:0] wcount, nwords, out_idx, nbeats;
    logic              fill_acc, beat_acc, is_last, full;

    assign full     = (wcount == WORDS_MAX);
    assign nbeats   = (nwords + ONE) >> 1;
    assign is_last  = (out_idx == nbeats - ONE);
    assign fill_acc = fill_valid & fill_ready;
    assign beat_acc = M_AXIS_TVALID & M_AXIS_TREADY;

    always_ff @(posedge ACLK) begin
        if (RESET) state <= S_FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (fill_acc && fill_last) state_nxt = S_PRIME;
            S_PRIME: state_nxt = S_DRAIN;
            S_DRAIN: if (beat_acc && is_last) state_nxt = S_FILL;
            default: state_nxt = S_FILL;
        endcase
    end

    // Words beyond capacity are still accepted so the packet framing stays intact.
    always_ff @(posedge ACLK) begin
        if (RESET) begin
            wcount  <= '0;
            nwords  <= '0;
            out_idx <= '0;
        end else begin
            case (state)
                S_FILL: if (fill_acc) begin
                    if (!full) wcount <= wcount + ONE;
                    if (fill_last) nwords <= full ? WORDS_MAX : wcount + ONE;
                end
                S_PRIME: out_idx <= '0;
                S_DRAIN: if (beat_acc) begin
                    if (is_last) begin
                        out_idx <= '0;
                        wcount  <= '0;
                    end else begin
                        out_idx <= out_idx + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // The buffer registers its read address, so advance it only when the current beat is consumed.
    always_comb begin
        fill_ready    = 1'b0;
        buf_wr32_en   = 1'b0;
        buf_wr32_addr = wcount;
        buf_wr32_data = fill_data;
        err_overflow  = 1'b0;
        buf_rd64_addr = '0;
        M_AXIS_TDATA  = buf_rd64_data;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TKEEP  = 8'h00;
        if (!RESET) begin
            case (state)
                S_FILL: begin
                    fill_ready   = 1'b1;
                    buf_wr32_en  = fill_valid & ~full;
                    err_overflow = fill_valid & full;
                end
                S_DRAIN: begin
                    M_AXIS_TVALID = 1'b1;
                    M_AXIS_TLAST  = is_last;
                    M_AXIS_TKEEP  = (is_last && nwords[0]) ? 8'h0F : 8'hFF;
                    buf_rd64_addr = (M_AXIS_TREADY && !is_last)
                                  ? out_idx[WC_WIDTH-1:0] + WC_WIDTH'(1)
                                  : out_idx[WC_WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nf10_axis_memcached_bufctrl.sv
// tb/tb_nf10_axis_memcached_bufctrl.sv - randomized self-checking bench for the buffer sequencer
module tb_nf10_axis_memcached_bufctrl;
    localparam int WC_MAX   = 190;
    localparam int WC_WIDTH = 8;
    localparam int CAP      = 2 * WC_MAX;

    logic                clk = 1'b0;
    logic                RESET;
    logic [31:0]         fill_data;
    logic                fill_valid, fill_last, fill_ready;
    logic [WC_WIDTH:0]   buf_wr32_addr;
    logic [31:0]         buf_wr32_data;
    logic                buf_wr32_en;
    logic [WC_WIDTH-1:0] buf_rd64_addr;
    logic [63:0]         buf_rd64_data;
    logic [63:0]         M_AXIS_TDATA;
    logic [7:0]          M_AXIS_TKEEP;
    logic                M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
    logic                err_overflow;

    int checks = 0;
    int failures = 0;

    logic [31:0] pkt[$];
    int          stored;
    int          pattern[$];

    // Buffer model: 32-bit write port, registered 64-bit read port.
    logic [31:0]         mem [0:511];
    logic [WC_WIDTH-1:0] rd_q;
    always @(posedge clk) begin
        if (buf_wr32_en) mem[buf_wr32_addr] <= buf_wr32_data;
        rd_q <= buf_rd64_addr;
    end
    assign buf_rd64_data = {mem[{rd_q, 1'b1}], mem[{rd_q, 1'b0}]};

    always #5 clk = ~clk;

    nf10_axis_memcached_bufctrl #(.WC_MAX(WC_MAX), .WC_WIDTH(WC_WIDTH)) dut (
        .ACLK(clk), .RESET(RESET),
        .fill_data(fill_data), .fill_valid(fill_valid), .fill_last(fill_last), .fill_ready(fill_ready),
        .buf_wr32_addr(buf_wr32_addr), .buf_wr32_data(buf_wr32_data), .buf_wr32_en(buf_wr32_en),
        .buf_rd64_addr(buf_rd64_addr), .buf_rd64_data(buf_rd64_data),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST), .err_overflow(err_overflow)
    );

    task automatic do_fill(input bit gaps, input string name);
        int n = pkt.size();
        int idx = 0;
        int wr_seen = 0;
        int ovf_seen = 0;
        bit exp_wr;
        stored = (n < CAP) ? n : CAP;
        while (idx < n) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                fill_valid = 1'b0; fill_last = 1'b0;
                #1;
                checks++;
                if (buf_wr32_en !== 1'b0 || fill_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL %s idle: wr_en=%b fill_ready=%b required 0/1", name, buf_wr32_en, fill_ready);
                end
            end else begin
                fill_valid = 1'b1; fill_data = pkt[idx]; fill_last = (idx == n - 1);
                #1;
                exp_wr = (idx < CAP);
                checks++;
                if (fill_ready !== 1'b1 || buf_wr32_en !== exp_wr || err_overflow !== !exp_wr) begin
                    failures++;
                    $display("FAIL %s word %0d: ready=%b wr_en=%b err=%b required 1/%b/%b",
                             name, idx, fill_ready, buf_wr32_en, err_overflow, exp_wr, !exp_wr);
                end
                if (exp_wr) begin
                    checks++;
                    if (buf_wr32_addr !== (WC_WIDTH+1)'(idx) || buf_wr32_data !== pkt[idx]) begin
                        failures++;
                        $display("FAIL %s write %0d: addr=%0d data=%h required %0d/%h",
                                 name, idx, buf_wr32_addr, buf_wr32_data, idx, pkt[idx]);
                    end
                end
                wr_seen += int'(buf_wr32_en);
                ovf_seen += int'(err_overflow);
                idx++;
            end
            @(posedge clk);
        end
        checks++;
        if (wr_seen != stored || ovf_seen != n - stored) begin
            failures++;
            $display("FAIL %s counts: writes=%0d overflows=%0d required %0d/%0d", name, wr_seen, ovf_seen, stored, n - stored);
        end
        @(negedge clk);
        fill_valid = 1'b0; fill_last = 1'b0;
        #1;
        checks++;
        if (fill_ready !== 1'b0 || M_AXIS_TVALID !== 1'b0 || buf_rd64_addr !== '0) begin
            failures++;
            $display("FAIL %s prime: ready=%b tvalid=%b rd_addr=%0d required 0/0/0", name, fill_ready, M_AXIS_TVALID, buf_rd64_addr);
        end
        @(posedge clk);
    endtask

    // mode 0: always ready, 1: random, 2: pattern queue then ready.
    task automatic do_drain(input int mode, input int max_beats, input string name);
        int nb = (stored + 1) / 2;
        int k = 0;
        int cyc = 0;
        bit prev_stall = 0;
        bit exp_last;
        logic [63:0] prev_data;
        logic [WC_WIDTH-1:0] prev_addr;
        logic [7:0] exp_keep;
        int exp_addr;
        while (k < nb && k < max_beats && cyc < 2000) begin
            @(negedge clk);
            if (mode == 0) M_AXIS_TREADY = 1'b1;
            else if (mode == 1) M_AXIS_TREADY = 1'($urandom_range(0, 1));
            else M_AXIS_TREADY = (cyc < pattern.size()) ? 1'(pattern[cyc]) : 1'b1;
            #1;
            cyc++;
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || fill_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s drain valid beat %0d: tvalid=%b ready=%b required 1/0", name, k, M_AXIS_TVALID, fill_ready);
            end
            if (prev_stall) begin
                checks++;
                if (M_AXIS_TDATA !== prev_data) begin
                    failures++;
                    $display("FAIL %s stall hold: tdata=%h required %h", name, M_AXIS_TDATA, prev_data);
                end
                if (!M_AXIS_TREADY) begin
                    checks++;
                    if (buf_rd64_addr !== prev_addr) begin
                        failures++;
                        $display("FAIL %s stall addr: rd_addr=%0d required %0d", name, buf_rd64_addr, prev_addr);
                    end
                end
            end
            exp_last = (k == nb - 1);
            exp_addr = (M_AXIS_TREADY && !exp_last) ? k + 1 : k;
            checks++;
            if (buf_rd64_addr !== WC_WIDTH'(exp_addr)) begin
                failures++;
                $display("FAIL %s rd_addr beat %0d: rd_addr=%0d required %0d", name, k, buf_rd64_addr, exp_addr);
            end
            if (M_AXIS_TREADY) begin
                exp_keep = (2 * k + 1 < stored) ? 8'hFF : 8'h0F;
                checks++;
                if (M_AXIS_TDATA[31:0] !== pkt[2*k] || M_AXIS_TKEEP !== exp_keep || M_AXIS_TLAST !== exp_last ||
                    (exp_keep == 8'hFF && M_AXIS_TDATA[63:32] !== pkt[2*k+1])) begin
                    failures++;
                    $display("FAIL %s beat %0d: tdata=%h keep=%h last=%b required lo=%h hi=%h keep=%h last=%b",
                             name, k, M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST, pkt[2*k],
                             (exp_keep == 8'hFF) ? pkt[2*k+1] : 32'h0, exp_keep, exp_last);
                end
                k++;
                prev_stall = 0;
            end else begin
                prev_stall = 1;
                prev_data = M_AXIS_TDATA;
                prev_addr = buf_rd64_addr;
            end
            @(posedge clk);
        end
        if (cyc >= 2000) begin
            failures++;
            checks++;
            $display("FAIL %s drain timeout: beats=%0d required %0d", name, k, nb);
        end
    endtask

    task automatic check_back_to_fill(input string name);
        @(negedge clk);
        M_AXIS_TREADY = 1'b1;
        #1;
        checks++;
        if (fill_ready !== 1'b1 || M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TKEEP !== 8'h00) begin
            failures++;
            $display("FAIL %s after last: ready=%b tvalid=%b last=%b keep=%h required 1/0/0/00",
                     name, fill_ready, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP);
        end
    endtask

    task automatic run_packet(input int mode, input bit gaps, input string name);
        do_fill(gaps, name);
        do_drain(mode, 1 << 30, name);
        check_back_to_fill(name);
    endtask

    task automatic test_reset();
        RESET = 1'b1; fill_valid = 1'b1; fill_last = 1'b0; fill_data = 32'hDEAD; M_AXIS_TREADY = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (fill_ready !== 1'b0 || M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 || M_AXIS_TKEEP !== 8'h00 ||
            buf_wr32_en !== 1'b0 || err_overflow !== 1'b0 || buf_rd64_addr !== '0) begin
            failures++;
            $display("FAIL reset state: ready=%b tvalid=%b last=%b keep=%h wr=%b err=%b rd=%0d required all 0",
                     fill_ready, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TKEEP, buf_wr32_en, err_overflow, buf_rd64_addr);
        end
        fill_valid = 1'b0;
        RESET = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (fill_ready !== 1'b1 || M_AXIS_TVALID !== 1'b0) begin
            failures++;
            $display("FAIL reset release: ready=%b tvalid=%b required 1/0", fill_ready, M_AXIS_TVALID);
        end
    endtask

    task automatic test_four_words();
        pkt = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_packet(0, 0, "four_words");
    endtask

    task automatic test_three_words();
        pkt = '{32'hA, 32'hB, 32'hC};
        run_packet(0, 0, "three_words");
    endtask

    task automatic test_single_word();
        pkt = '{32'h5A5A_0001};
        run_packet(0, 0, "single_word");
    endtask

    task automatic test_backpressure();
        pkt.delete();
        for (int i = 0; i < 6; i++) pkt.push_back($urandom);
        pattern = '{1, 0, 0, 1, 0, 1};
        run_packet(2, 0, "backpressure");
    endtask

    task automatic test_overflow();
        pkt.delete();
        for (int i = 0; i < CAP + 2; i++) pkt.push_back($urandom);
        run_packet(0, 0, "overflow");
    endtask

    task automatic test_reset_mid_drain();
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back($urandom);
        do_fill(0, "mid_reset");
        do_drain(0, 1, "mid_reset");
        @(negedge clk);
        RESET = 1'b1;
        M_AXIS_TREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || fill_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset during: tvalid=%b ready=%b required 0/0", M_AXIS_TVALID, fill_ready);
        end
        RESET = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (M_AXIS_TVALID !== 1'b0 || fill_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset after: tvalid=%b ready=%b required 0/1", M_AXIS_TVALID, fill_ready);
        end
        pkt = '{32'hCAFE_0000, 32'hBEEF_0001};
        run_packet(0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int p = 0; p < 12; p++) begin
            pkt.delete();
            for (int i = 0, n = $urandom_range(1, 40); i < n; i++) pkt.push_back($urandom);
            run_packet(1, 1, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            pkt.delete();
            for (int i = 0; i < p + 2; i++) pkt.push_back($urandom);
            do_fill(0, "back_to_back");
            do_drain(0, 1 << 30, "back_to_back");
        end
        check_back_to_fill("back_to_back");
    endtask

    initial begin
        RESET = 1'b1; fill_valid = 1'b0; fill_last = 1'b0; fill_data = '0; M_AXIS_TREADY = 1'b0;
        test_reset();
        test_four_words();
        test_three_words();
        test_single_word();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
